// File: rtl/exe_hazard_ctrl.sv
// Purpose : EXE-stage hazard control. Shadows the EXE/MEM destinations, compares them with
//           the ID sources, and produces forward selects, the load-use/no-forward stall and the branch flush.
// Latency : hazard_stall/flush are combinational. Forward selects are registered and load as the ID instruction enters EXE.
// Backpressure : freeze holds every register. hazard_stall inserts a bubble into EXE and holds ID.
//
// Ports:
//   clk, rst (sync, active-low)
//   fwd_en         - 1: forwarding mode, 0: stall-only mode
//   freeze         - global pipeline hold; slots, selects and counter keep their value
//   id_*           - decoded fields of the instruction currently in ID
//   exe_branch_taken - taken branch in EXE; kills IF/ID and the ID instruction
//   val_rn_sel/val_rm_sel - 00 regfile, 01 EXE/MEM result, 10 WB value
//   hazard_stall, flush, stall_count (saturating)
module exe_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_mem_read,
  input  logic             exe_branch_taken,
  output logic [1:0]       val_rn_sel,
  output logic [1:0]       val_rm_sel,
  output logic             hazard_stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             v;
    logic             wb;
    logic [REG_W-1:0] dest;
    logic             mrd;
  } exe_slot_t;

  typedef struct packed {
    logic             v;
    logic             wb;
    logic [REG_W-1:0] dest;
  } mem_slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  exe_slot_t exe_slot;
  mem_slot_t mem_slot;

  logic       s1_exe, s2_exe, s1_mem, s2_mem;
  logic       exe_hit, mem_hit, stall_raw, id_adv;
  logic [1:0] rn_nxt, rm_nxt;

  // Source/slot comparisons.
  always_comb begin
    s1_exe = id_use_src1 && exe_slot.v && exe_slot.wb && (id_src1 == exe_slot.dest);
    s2_exe = id_use_src2 && exe_slot.v && exe_slot.wb && (id_src2 == exe_slot.dest);
    s1_mem = id_use_src1 && mem_slot.v && mem_slot.wb && (id_src1 == mem_slot.dest);
    s2_mem = id_use_src2 && mem_slot.v && mem_slot.wb && (id_src2 == mem_slot.dest);
    exe_hit = s1_exe || s2_exe;
    mem_hit = s1_mem || s2_mem;
  end

  // With forwarding only a load in EXE cannot be bypassed. Without it, any producer
  // still in EXE or MEM blocks; WB is covered by write-before-read in the register file.
  assign stall_raw    = fwd_en ? (exe_hit && exe_slot.mrd) : (exe_hit || mem_hit);
  // Both outputs are held low while reset is asserted. A taken branch kills the ID
  // instruction, so its hazard is irrelevant.
  assign flush        = rst && exe_branch_taken;
  assign hazard_stall = rst && id_valid && stall_raw && !exe_branch_taken;
  assign id_adv       = id_valid && !hazard_stall && !flush;

  // Forward selects for the instruction about to enter EXE. The EXE slot is the younger
  // producer, so it wins over MEM.
  always_comb begin
    rn_nxt = SEL_RF;
    rm_nxt = SEL_RF;
    if (id_adv && fwd_en) begin
      if (s1_exe)      rn_nxt = SEL_EXE;
      else if (s1_mem) rn_nxt = SEL_MEM;
      if (s2_exe)      rm_nxt = SEL_EXE;
      else if (s2_mem) rm_nxt = SEL_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_slot    <= '0;
      mem_slot    <= '0;
      val_rn_sel  <= SEL_RF;
      val_rm_sel  <= SEL_RF;
      stall_count <= '0;
    end else if (!freeze) begin
      mem_slot.v    <= exe_slot.v;
      mem_slot.wb   <= exe_slot.wb;
      mem_slot.dest <= exe_slot.dest;
      if (id_adv) begin
        exe_slot.v    <= 1'b1;
        exe_slot.wb   <= id_wb_en;
        exe_slot.dest <= id_dest;
        exe_slot.mrd  <= id_mem_read;
      end else begin
        exe_slot <= '0;
      end
      val_rn_sel <= rn_nxt;
      val_rm_sel <= rm_nxt;
      if (hazard_stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
module tb_exe_hazard_ctrl;
  localparam int RW = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fwd_en, freeze, id_valid;
  logic [RW-1:0] id_src1, id_src2, id_dest;
  logic          id_use_src1, id_use_src2, id_wb_en, id_mem_read, exe_branch_taken;
  logic [1:0]    val_rn_sel, val_rm_sel;
  logic          hazard_stall, flush;
  logic [CW-1:0] stall_count;

  exe_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .freeze(freeze), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .exe_branch_taken(exe_branch_taken), .val_rn_sel(val_rn_sel), .val_rm_sel(val_rm_sel),
    .hazard_stall(hazard_stall), .flush(flush), .stall_count(stall_count)
  );

  typedef struct {
    logic          rs, f, fz, vl;
    logic [RW-1:0] s1;
    logic          u1;
    logic [RW-1:0] s2;
    logic          u2, wb;
    logic [RW-1:0] d;
    logic          mrd, br;
    logic          es, ef;
    logic [1:0]    ern, erm;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tv[32];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic rs, f, fz, vl, input logic [RW-1:0] s1, input logic u1,
                              input logic [RW-1:0] s2, input logic u2, wb, input logic [RW-1:0] d,
                              input logic mrd, br, es, ef, input logic [1:0] ern, erm,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.rs = rs; v.f = f; v.fz = fz; v.vl = vl; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.wb = wb; v.d = d; v.mrd = mrd; v.br = br; v.es = es; v.ef = ef; v.ern = ern; v.erm = erm;
    v.ec = ec;
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x > (1 << CW) - 1) ? (1 << CW) - 1 : x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, idx, act, exp_v);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rs; fwd_en = v.f; freeze = v.fz; id_valid = v.vl;
    id_src1 = v.s1; id_use_src1 = v.u1; id_src2 = v.s2; id_use_src2 = v.u2;
    id_wb_en = v.wb; id_dest = v.d; id_mem_read = v.mrd; exe_branch_taken = v.br;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
  task automatic run(input vec_t v, input int idx);
    apply(v);
    #3;
    chk("hazard_stall", idx, 16'(hazard_stall), 16'(v.es));
    chk("flush",        idx, 16'(flush),        16'(v.ef));
    chk("val_rn_sel",   idx, 16'(val_rn_sel),   16'(v.ern));
    chk("val_rm_sel",   idx, 16'(val_rm_sel),   16'(v.erm));
    chk("stall_count",  idx, 16'(stall_count),  16'(v.ec));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_reset_inputs();
    rst = 1'b0; fwd_en = 1'($urandom); freeze = 1'($urandom); id_valid = 1'b1;
    id_src1 = RW'($urandom); id_src2 = RW'($urandom); id_dest = RW'($urandom);
    id_use_src1 = 1'($urandom); id_use_src2 = 1'($urandom); id_wb_en = 1'($urandom);
    id_mem_read = 1'($urandom); exe_branch_taken = 1'b1;
  endtask

  initial begin
    int c;
    // rst,f,fz,vl, s1,u1,s2,u2, wb,d,mrd, br, es,ef,ern,erm,cnt
    tv[0]  = mk(1,1,0,1, 0,0,0,0, 1,1,0, 0, 0,0,0,0,0);   // ADD R1
    tv[1]  = mk(1,1,0,1, 1,1,0,0, 0,0,0, 0, 0,0,0,0,0);   // SUB uses R1
    tv[2]  = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,1,0,0);
    tv[3]  = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0,0);
    tv[4]  = mk(1,1,0,1, 0,0,0,0, 1,2,0, 0, 0,0,0,0,0);   // ADD R2
    tv[5]  = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0,0);
    tv[6]  = mk(1,1,0,1, 0,0,2,1, 1,6,0, 0, 0,0,0,0,0);   // ORR src2=R2
    tv[7]  = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,2,0);
    tv[8]  = mk(1,1,0,1, 0,0,0,0, 1,3,0, 0, 0,0,0,0,0);   // ADD R3
    tv[9]  = mk(1,1,0,1, 0,0,0,0, 1,3,0, 0, 0,0,0,0,0);   // ADD R3
    tv[10] = mk(1,1,0,1, 3,1,3,1, 0,0,0, 0, 0,0,0,0,0);   // use R3 twice
    tv[11] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,1,1,0);
    tv[12] = mk(1,1,0,1, 0,0,0,0, 1,4,1, 0, 0,0,0,0,0);   // LDR R4
    tv[13] = mk(1,1,0,1, 4,1,0,0, 1,7,0, 0, 1,0,0,0,0);   // ADD uses R4: load-use
    tv[14] = mk(1,1,0,1, 4,1,0,0, 1,7,0, 0, 0,0,0,0,1);
    tv[15] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,2,0,1);
    tv[16] = mk(1,0,0,1, 0,0,0,0, 1,5,0, 0, 0,0,0,0,1);   // stall-only: ADD R5
    tv[17] = mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0,1);
    tv[18] = mk(1,0,1,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0,2);   // frozen
    tv[19] = mk(1,0,1,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0,2);
    tv[20] = mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0,2);
    tv[21] = mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 0,0,0,0,3);
    tv[22] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0,3);
    tv[23] = mk(1,1,0,1, 0,0,0,0, 1,8,1, 0, 0,0,0,0,3);   // LDR R8
    tv[24] = mk(1,1,0,1, 0,0,8,1, 1,9,0, 1, 0,1,0,0,3);   // load-use + taken branch
    tv[25] = mk(1,1,0,1, 9,1,0,0, 0,0,0, 0, 0,0,0,0,3);   // R9 must not be in flight
    tv[26] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0,3);
    tv[27] = mk(1,1,0,1, 0,0,0,0, 1,10,0, 0, 0,0,0,0,3);  // ADD R10
    tv[28] = mk(1,1,0,1, 10,1,0,0, 0,0,0, 0, 0,0,0,0,3);
    tv[29] = mk(1,1,1,0, 0,0,0,0, 0,0,0, 1, 0,1,1,0,3);   // frozen, flush still live
    tv[30] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,1,0,3);
    tv[31] = mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0,3);

    // Reset with random inputs for two edges.
    rand_reset_inputs();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      rand_reset_inputs();
      #3;
      chk("rst_hazard_stall", r, 16'(hazard_stall), 16'd0);
      chk("rst_flush",        r, 16'(flush),        16'd0);
      chk("rst_val_rn_sel",   r, 16'(val_rn_sel),   16'd0);
      chk("rst_val_rm_sel",   r, 16'(val_rm_sel),   16'd0);
      chk("rst_stall_count",  r, 16'(stall_count),  16'd0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 32; i++) run(tv[i], i);

    // Drive the counter into saturation with stall-only producer/consumer pairs.
    c = 3;
    for (int k = 0; k < 7; k++) begin
      run(mk(1,0,0,1, 0,0,0,0, 1,5,0, 0, 0,0,0,0, CW'(c)), 100 + 4*k);
      run(mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0, CW'(c)), 101 + 4*k);
      c = sat(c + 1);
      run(mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0, CW'(c)), 102 + 4*k);
      c = sat(c + 1);
      run(mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 0,0,0,0, CW'(c)), 103 + 4*k);
    end

    // Reset asserted in the middle of a stall.
    run(mk(1,0,0,1, 0,0,0,0, 1,5,0, 0, 0,0,0,0, CW'(c)), 200);
    run(mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 1,0,0,0, CW'(c)), 201);
    run(mk(0,0,0,1, 5,1,0,0, 0,0,0, 1, 0,0,0,0, CW'(c)), 202);
    run(mk(1,0,0,1, 5,1,0,0, 0,0,0, 0, 0,0,0,0, 0),      203);
    run(mk(1,1,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0, 0),      204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_hazard_ctrl.md
Name: exe_hazard_ctrl

Overview:
Pipeline hazard controller for the execute stage. It keeps a registered shadow of the destinations held by the EXE and MEM stages and compares them with the sources of the instruction in ID. From that it produces the registered Rn/Rm operand-forwarding selects consumed by the execute stage, the load-use / no-forwarding stall, and the branch flush. It sits beside the ID/EXE pipeline register and is advanced by the same enables.

Parameters:
REG_W, 4, register index width
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  reset
fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
freeze  in  1  global pipeline freeze (memory wait); holds all state
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_W  Rn index
id_src2  in  REG_W  Rm / Rd-store index
id_use_src1  in  1  instruction reads Rn
id_use_src2  in  1  instruction reads src2
id_wb_en  in  1  instruction writes a register
id_dest  in  REG_W  destination index
id_mem_read  in  1  instruction is a load
exe_branch_taken  in  1  branch in EXE is taken this cycle
val_rn_sel  out  2  Rn forward select for the instruction in EXE
val_rm_sel  out  2  Rm forward select for the instruction in EXE
hazard_stall  out  1  hold PC and IF/ID; insert bubble into ID/EXE
flush  out  1  kill IF/ID and the ID instruction
stall_count  out  CNT_W  number of stall cycles taken, saturating

Behaviour:
- Reset: one clock; reset is synchronous and active-low (rst=0 at a clk rising edge resets).
- Reset values: all shadow slots invalid; val_rn_sel = val_rm_sel = 2'b00; stall_count = 0. hazard_stall and flush are 0 while rst=0.
- Shadow slots:
  - EXE slot holds {v, wb, dest, mrd}.
  - MEM slot holds {v, wb, dest}.
- Slot advance on each edge when freeze=0:
  - MEM slot <= EXE slot.
  - EXE slot <= ID fields if id_valid && !hazard_stall && !flush; otherwise a bubble (v=0).
- Match condition: a source matches a slot when use_srcX && slot.v && slot.wb && srcX == slot.dest.
- Stall (combinational), with fwd_en=1: hazard_stall = id_valid && EXE-slot match on either source && EXE.mrd (load-use). Exactly 1 stall cycle, after which the producer is in the MEM slot.
- Stall with fwd_en=0: hazard_stall = id_valid && (EXE-slot match || MEM-slot match) on either source. A hazard against WB is resolved by the register file's write-before-read.
- Forward selects are registered and load on the same edge the ID instruction enters EXE.
  - fwd_en=1, per source:
    - 2'b01 (Val_X_exe, result in EXE/MEM register) if it matches the EXE slot.
    - Else 2'b10 (Val_X_mem, WB value) if it matches the MEM slot.
    - Else 2'b00.
  - EXE-slot match has priority when both slots match.
  - fwd_en=0: selects are always 2'b00. Encoding 2'b11 is never produced.
  - Bubble or stall entering EXE: both selects load 2'b00.
- flush = exe_branch_taken (combinational). It overrides hazard_stall: when flush=1, hazard_stall is forced to 0.
- freeze=1: slots, selects and stall_count hold. hazard_stall and flush are still evaluated combinationally.
- stall_count: +1 on each edge where freeze=0 && hazard_stall=1; saturates at all-ones.
- rst asserted mid-stall: the next edge clears all state. The stall ends because the slots become invalid.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> selects 00, stall_count 0, hazard_stall 0, flush 0. Release -> first independent instruction gives no stall.
- Forwarding, back-to-back: ADD R1 (wb, dest 1), then SUB src1=1 with fwd_en=1 -> no stall; when SUB enters EXE, val_rn_sel=01 for 1 cycle.
- Forwarding, distance 2: ADD R2, NOP, ORR src2=2 -> val_rm_sel=10. Same dest in both slots (ADD R3; ADD R3; use R3) -> sel 01 (priority).
- Load-use: LDR R4, then ADD src1=4, fwd_en=1 -> hazard_stall=1 for exactly 1 cycle, then val_rn_sel=10; stall_count increments by 1.
- Stall-only mode: fwd_en=0, ADD R5 then use R5 -> hazard_stall for 2 cycles, selects 00, stall_count += 2. freeze=1 during the stall -> stall_count and slots hold.
- Branch: exe_branch_taken=1 while ID has a load-use hazard -> flush=1, hazard_stall=0, next EXE slot is a bubble, selects 00. Counter at all-ones plus one more stall -> stays all-ones.
